// File: rtl/fifo_pkg.sv
// fifo_pkg: FSM encoding and Gray helpers shared by the FIFO write and read sides.
package fifo_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, WRITE = 2'b01, FULL = 2'b10} state_t;
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return (bin >> 1) ^ bin;
    endfunction
endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: combinational Gray to binary conversion.
module fifo_gray2bin #(
    parameter int W = 3
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end
endmodule

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-side pointer, full and overflow control for the dual-clock FIFO.
// Define FIFO_WR_ALMOST_FULL_EN to enable walmost_full; otherwise it is tied to 0.
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_SZ   = 2,
    parameter int AF_LEVEL = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic [PTR_SZ:0]   wq2_raddr,
    output logic              write_en,
    output logic [PTR_SZ-1:0] waddr,
    output logic [PTR_SZ:0]   waddr_gray,
    output logic              wfull,
    output logic              wovf,
    output logic              walmost_full
);
    // Full when the write Gray pointer equals the read one with its top two bits inverted.
    localparam logic [PTR_SZ:0] FULL_MASK = (PTR_SZ+1)'(3) << (PTR_SZ - 1);
    if (PTR_SZ < 1 || AF_LEVEL < 1 || AF_LEVEL > 2**PTR_SZ) begin : g_bad_cfg
        $error("fifo_write_ctrl: illegal PTR_SZ/AF_LEVEL");
    end
    state_t state, state_next;
    logic [PTR_SZ:0] wbin, wbin_next, wgray_next;
    logic full_next;
    assign write_en   = rst & winc & ~wfull;
    assign wfull      = (state == FULL);
    assign wbin_next  = wbin + (PTR_SZ+1)'(write_en);
    assign wgray_next = (PTR_SZ+1)'(bin2gray(32'(wbin_next)));
    assign full_next  = (wgray_next == (wq2_raddr ^ FULL_MASK));
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE, WRITE: state_next = full_next ? FULL : (write_en ? WRITE : IDLE);
            FULL:        state_next = full_next ? FULL : IDLE;
            default:     state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wbin       <= '0;
            waddr      <= '0;
            waddr_gray <= '0;
            wovf       <= 1'b0;
            state      <= IDLE;
        end else begin
            wbin       <= wbin_next;
            waddr      <= wbin_next[PTR_SZ-1:0];
            waddr_gray <= wgray_next;
            wovf       <= winc & wfull;
            state      <= state_next;
        end
    end
`ifdef FIFO_WR_ALMOST_FULL_EN
    logic [PTR_SZ:0] rbin, occ;
    fifo_gray2bin #(.W(PTR_SZ + 1)) u_gray2bin (.gray(wq2_raddr), .bin(rbin));
    assign occ = wbin_next - rbin;
    always_ff @(posedge clk) begin
        if (!rst) walmost_full <= 1'b0;
        else      walmost_full <= (occ >= (PTR_SZ+1)'(AF_LEVEL));
    end
`else
    assign walmost_full = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb_fifo_write_ctrl: directed self-checking bench for fifo_write_ctrl with PTR_SZ=2, AF_LEVEL=3.
module tb_fifo_write_ctrl;
    logic clk = 1'b0;
    logic rst, winc;
    logic [2:0] wq2_raddr;
    logic write_en, wfull, wovf, walmost_full;
    logic [1:0] waddr;
    logic [2:0] waddr_gray;
    int checks = 0;
    int errors = 0;

    fifo_write_ctrl #(.PTR_SZ(2), .AF_LEVEL(3)) dut (
        .clk(clk), .rst(rst), .winc(winc), .wq2_raddr(wq2_raddr),
        .write_en(write_en), .waddr(waddr), .waddr_gray(waddr_gray),
        .wfull(wfull), .wovf(wovf), .walmost_full(walmost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] a, input logic [2:0] g,
                            input logic f, input logic o);
        chk({tag, ".waddr"}, 8'(waddr), 8'(a));
        chk({tag, ".gray"}, 8'(waddr_gray), 8'(g));
        chk({tag, ".wfull"}, 8'(wfull), 8'(f));
        chk({tag, ".wovf"}, 8'(wovf), 8'(o));
    endtask

    initial begin
        logic [1:0] fill_a [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [2:0] fill_g [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
        rst = 1'b0; winc = 1'b1; wq2_raddr = 3'b000;
        #1;
        chk("rst.write_en", 8'(write_en), 8'd0);
        step(); step();
        chk("rst.write_en2", 8'(write_en), 8'd0);
        chk_outs("rst", 2'd0, 3'b000, 1'b0, 1'b0);
        chk("rst.almost", 8'(walmost_full), 8'd0);

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fill%0d.write_en", i), 8'(write_en), 8'd1);
            step();
            chk_outs($sformatf("fill%0d", i), fill_a[i], fill_g[i], i == 3, 1'b0);
        end

        #1;
        chk("ovf.write_en", 8'(write_en), 8'd0);
        step();
        chk_outs("ovf", 2'd0, 3'b110, 1'b1, 1'b1);
        winc = 1'b0;
        step();
        chk("ovf.end", 8'(wovf), 8'd0);

        wq2_raddr = 3'b001;
        step();
        chk_outs("free", 2'd0, 3'b110, 1'b0, 1'b0);
        winc = 1'b1;
        #1;
        chk("refill.write_en", 8'(write_en), 8'd1);
        step();
        chk_outs("refill", 2'd1, 3'b111, 1'b1, 1'b0);
        winc = 1'b0;

        rst = 1'b0;
        step();
        rst = 1'b1; wq2_raddr = 3'b000; winc = 1'b1;
        step(); step();
        chk_outs("mid", 2'd2, 3'b011, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst.write_en", 8'(write_en), 8'd0);
        step();
        chk_outs("midrst", 2'd0, 3'b000, 1'b0, 1'b0);
        chk("midrst.almost", 8'(walmost_full), 8'd0);

        rst = 1'b1;
        step(); step();
        chk("af2", 8'(walmost_full), 8'd0);
        step();
`ifdef FIFO_WR_ALMOST_FULL_EN
        chk("af3", 8'(walmost_full), 8'd1);
`else
        chk("af3", 8'(walmost_full), 8'd0);
`endif
        winc = 1'b0; wq2_raddr = 3'b001;
        step();
        chk("af_free", 8'(walmost_full), 8'd0);
        chk_outs("af_free", 2'd3, 3'b010, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
- Write-side pointer and flag controller for the dual-clock FIFO. It is the upstream partner of the read-side logic.
- Accepts write requests in the write clock domain and drives the memory write strobe and address.
- Maintains a binary and a Gray write pointer, and exports the Gray pointer for synchronisation into the read domain.
- Detects full against the read Gray pointer, already double-flopped into this domain.

Parameters:
- PTR_SZ, 2, entry index width in bits; DEPTH = 2**PTR_SZ; legal PTR_SZ >= 1.
- AF_LEVEL, 3, almost-full occupancy threshold (1..DEPTH); used only with the optional feature.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  synchronous active-low reset, sampled on rising clk.
- winc  input  1  write request, sampled on rising clk.
- wq2_raddr  input  PTR_SZ+1  read Gray pointer, already synchronised into clk domain.
- write_en  output  1  memory write strobe, combinational.
- waddr  output  PTR_SZ  memory write address (binary pointer LSBs), registered.
- waddr_gray  output  PTR_SZ+1  Gray write pointer to read-domain synchroniser, registered.
- wfull  output  1  FIFO full, registered.
- wovf  output  1  one-cycle overflow pulse, registered.
- walmost_full  output  1  almost-full flag, registered (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low. While rst=0 at a rising edge:
  - wbin, waddr, waddr_gray <= 0.
  - wfull, wovf, walmost_full <= 0.
  - FSM <= IDLE.
- write_en = rst & winc & ~wfull. The memory writes at the current waddr on the same edge; zero added latency.
- Pointer advance:
  - wbin_next = wbin + write_en, PTR_SZ+1 bits, natural wrap mod 2*DEPTH.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - On each edge: wbin <= wbin_next; waddr <= wbin_next[PTR_SZ-1:0]; waddr_gray <= wgray_next.
- Full condition: full_next = (wgray_next == {~wq2_raddr[PTR_SZ:PTR_SZ-1], wq2_raddr[PTR_SZ-2:0]}).
  - For PTR_SZ=1, both bits are inverted.
- FSM states (2-bit): IDLE, WRITE, FULL. wfull = (state == FULL), so wfull is a registered output.
  - IDLE -> FULL if full_next; else -> WRITE if write_en; else stay IDLE.
  - WRITE -> FULL if full_next; else -> WRITE if write_en; else -> IDLE.
  - FULL -> stay FULL while full_next; else -> IDLE.
  - Any unused encoding -> IDLE.
- wfull deasserts one edge after a changed wq2_raddr breaks the full condition. This is pessimistic by the synchroniser delay, which is intended.
- Overflow: wovf <= rst & winc & wfull.
  - The pulse appears in the cycle after the rejected request.
  - Pointers are unchanged and nothing is written.
- Simultaneous events:
  - A write accepted on the edge where the reader frees space is evaluated with the new wq2_raddr.
  - A write that makes the FIFO full sets wfull on that same edge.
- Wrap-around: the MSB of wbin toggles every DEPTH writes. Gray code changes exactly one bit per accepted write.
- Reset mid-operation: write_en is forced to 0 in every cycle where rst=0. State is discarded; no partial write.

Optional Feature:
- Macro: FIFO_WR_ALMOST_FULL_EN.
- With the macro defined:
  - wq2_raddr is converted Gray->binary to give rbin.
  - occ = wbin_next - rbin, PTR_SZ+1 bits, modular.
  - walmost_full <= (occ >= AF_LEVEL).
  - Reset value is 0.
- Without the macro: walmost_full is tied to 0, and no conversion logic is present. The port stays on the interface so instantiations never change.

Decomposition:
- Shared package fifo_pkg holds:
  - the FSM state localparams IDLE=2'b00, WRITE=2'b01, FULL=2'b10, shared with the read-side FSM encoding;
  - a bin2gray function.
- One natural sub-module: fifo_gray2bin (parameter W).
  - Output bit i = XOR reduction of gray >> i, purely combinational.
  - Instantiated only under FIFO_WR_ALMOST_FULL_EN.
  - Reusable by the read side.

Test Plan:
All scenarios use PTR_SZ=2.
- Reset: hold rst=0 for 2 edges with winc=1 -> write_en=0; waddr=0, waddr_gray=000, wfull=0, wovf=0, walmost_full=0.
- Fill: wq2_raddr=000, winc=1 for 4 edges -> write_en=1 each cycle; waddr 1,2,3,0; waddr_gray 001,011,010,110; wfull=1 after the 4th edge.
- Overflow: continue winc=1 while full -> write_en=0, wovf=1 one cycle later, waddr and waddr_gray held at 0 and 110.
- Free one slot: set wq2_raddr=001 with winc=0 -> wfull=0 on the next edge. Then one write -> waddr_gray=111, wfull=1 again.
- Mid-operation reset: after 2 writes, pulse rst=0 with winc=1 -> write_en=0 in the reset cycle; all outputs return to reset values on that edge.
- Almost full (macro defined, AF_LEVEL=3): 3 writes from empty -> walmost_full=1 after the 3rd edge. Advance wq2_raddr to 001 -> walmost_full=0 next edge.
